// File: rtl/vadd_pkg.sv
// Shared types and helpers for the sequential vector add/sub unit.
// Holds FSM state encoding, index-width helper and saturation constants.
package vadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WRIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ELEM_W_DEF = 16;
  localparam logic [ELEM_W_DEF-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [ELEM_W_DEF-1:0] SAT_MIN = 16'h8000;

  // Never returns 0 so a single-chunk configuration still gets a legal index vector.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [63:0] sat_max_w(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_w(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/vadd_lane.sv
// One combinational add/sub lane with signed overflow detect and optional clamp.
// Zero latency; no flow control.
module vadd_lane
  import vadd_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  input  logic         sat_i,
  output logic [W-1:0] r_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAXV = W'(sat_max_w(W));
  localparam logic [W-1:0] MINV = W'(sat_min_w(W));

  logic [W-1:0] b_x;
  logic [W-1:0] r;
  logic         ovf;

  assign b_x = sub_i ? ~b_i : b_i;
  assign r   = a_i + b_x + {{(W-1){1'b0}}, sub_i};

  // In both modes an overflowed result carries the wrong sign relative to a.
  assign ovf = (sub_i ? (a_i[W-1] != b_i[W-1]) : (a_i[W-1] == b_i[W-1]))
               && (r[W-1] != a_i[W-1]);

  assign ovf_o = ovf;
  assign r_o   = (sat_i && ovf) ? (a_i[W-1] ? MINV : MAXV) : r;

endmodule

// File: rtl/vadd_vec_seq.sv
// Sequential vector add/sub: latches operands on start, PAR lanes per clock.
// write one cycle after the last chunk, done after that; start low aborts to IDLE.
module vadd_vec_seq
  import vadd_pkg::*;
#(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 8,
  parameter int PAR      = 2
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [NUM_ELEM*ELEM_W-1:0]   A,
  input  logic [NUM_ELEM*ELEM_W-1:0]   B,
  input  logic                         Sub,
  input  logic                         Sat,
  input  logic                         start,
  output logic [NUM_ELEM*ELEM_W-1:0]   SumV,
  output logic [NUM_ELEM-1:0]          OvMask,
  output logic                         V,
  output logic                         write,
  output logic                         done
);

  localparam int NCHUNK = NUM_ELEM / PAR;
  localparam int IDX_W  = clog2_min1(NCHUNK);
  localparam int VW     = NUM_ELEM * ELEM_W;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [VW-1:0]        a_q, b_q;
  logic                 sub_q, sat_q;
  logic [VW-1:0]        sumv_q;
  logic [NUM_ELEM-1:0]  ovm_q;
  logic                 v_q;
  logic                 last_chunk;

  logic [ELEM_W-1:0]    lane_a [PAR];
  logic [ELEM_W-1:0]    lane_b [PAR];
  logic [ELEM_W-1:0]    lane_r [PAR];
  logic [PAR-1:0]       lane_ovf;

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_chunk) state_d = WRIT;
      WRIT:    state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (!start) state_d = IDLE;
  end

  always_comb begin
    write = (state_q == WRIT);
    done  = (state_q == DONE);
  end

  // Static chunk mux keeps every operand slice constant-indexed.
  always_comb begin
    for (int l = 0; l < PAR; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      for (int c = 0; c < NCHUNK; c++) begin
        if (idx_q == IDX_W'(c)) begin
          lane_a[l] = a_q[(c*PAR+l)*ELEM_W +: ELEM_W];
          lane_b[l] = b_q[(c*PAR+l)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  for (genvar l = 0; l < PAR; l++) begin : g_lane
    vadd_lane #(.W(ELEM_W)) u_lane (
      .a_i   (lane_a[l]),
      .b_i   (lane_b[l]),
      .sub_i (sub_q),
      .sat_i (sat_q),
      .r_o   (lane_r[l]),
      .ovf_o (lane_ovf[l])
    );
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      idx_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sat_q  <= 1'b0;
      sumv_q <= '0;
      ovm_q  <= '0;
      v_q    <= 1'b0;
    end else if (!start) begin
      v_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_q    <= A;
          b_q    <= B;
          sub_q  <= Sub;
          sat_q  <= Sat;
          idx_q  <= '0;
          sumv_q <= '0;
          ovm_q  <= '0;
          v_q    <= 1'b0;
        end
        RUN: begin
          for (int e = 0; e < NUM_ELEM; e++) begin
            if (idx_q == IDX_W'(e / PAR)) begin
              sumv_q[e*ELEM_W +: ELEM_W] <= lane_r[e % PAR];
              ovm_q[e]                   <= lane_ovf[e % PAR];
            end
          end
          v_q <= v_q | (|lane_ovf);
          if (!last_chunk) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign SumV   = sumv_q;
  assign OvMask = ovm_q;
  assign V      = v_q;

endmodule
